// File: rtl/operand_fetch_pkg.sv
// Shared types and widths for the operand-fetch stage.
// Holds the bypass-source encoding and the ID/EX register layout.
package riscv_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int CTRL_W   = 16;

    typedef enum logic [2:0] {
        FWD_ZERO = 3'd0,
        FWD_EX   = 3'd1,
        FWD_MEM  = 3'd2,
        FWD_WB   = 3'd3,
        FWD_RF   = 3'd4
    } fwd_sel_e;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [REG_AW-1:0] rd;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       pc;
    } idex_t;

endpackage

// File: rtl/operand_fetch_bypass.sv
// Combinational operand resolution for one source register.
// Picks the youngest in-flight producer and flags an unresolvable load-use hazard.
module operand_bypass
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 5
) (
    input  logic                  use_rs,
    input  logic [AW-1:0]         rs,
    input  logic                  ex_wr_en,
    input  logic                  ex_is_load,
    input  logic [AW-1:0]         ex_rd,
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic                  mem_wr_en,
    input  logic [AW-1:0]         mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  wb_wr_en,
    input  logic [AW-1:0]         wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  hazard
);

    fwd_sel_e sel_s;
    logic     nz_s;

    // Source selection in age order; an unused source never matches anything.
    always_comb begin
        sel_s  = FWD_RF;
        nz_s   = (rs != {AW{1'b0}});
        hazard = use_rs && nz_s && ex_wr_en && ex_is_load && (ex_rd == rs);
        if (!use_rs) begin
            sel_s = FWD_RF;
        end else if (!nz_s) begin
            sel_s = FWD_ZERO;
        end else if (ex_wr_en && !ex_is_load && (ex_rd == rs)) begin
            sel_s = FWD_EX;
        end else if (mem_wr_en && (mem_rd == rs)) begin
            sel_s = FWD_MEM;
        end else if (wb_wr_en && (wb_rd == rs)) begin
            // The register file does not write through, so WB must be bypassed.
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_RF;
        end
    end

    // Operand mux driven by the selection.
    always_comb begin
        case (sel_s)
            FWD_ZERO: operand = {DATA_WIDTH{1'b0}};
            FWD_EX:   operand = ex_data;
            FWD_MEM:  operand = mem_data;
            FWD_WB:   operand = wb_data;
            FWD_RF:   operand = rf_data;
            default:  operand = rf_data;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: register read, bypass, load-use stall and
// the ID/EX pipeline register behind a valid/ready handshake.
module operand_fetch
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int CTRL_WIDTH    = 16,
    localparam int AW           = $clog2(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_rs1,
    input  logic [AW-1:0]         in_rs2,
    input  logic                  in_use_rs1,
    input  logic                  in_use_rs2,
    input  logic [AW-1:0]         in_rd,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [31:0]           in_pc,
    output logic [AW-1:0]         rf_rd0,
    output logic [AW-1:0]         rf_rd1,
    input  logic [DATA_WIDTH-1:0] rf_data0,
    input  logic [DATA_WIDTH-1:0] rf_data1,
    input  logic                  ex_wr_en,
    input  logic                  ex_is_load,
    input  logic [AW-1:0]         ex_rd,
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic                  mem_wr_en,
    input  logic [AW-1:0]         mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  wb_wr_en,
    input  logic [AW-1:0]         wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [AW-1:0]         out_rd,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [31:0]           out_pc,
    output logic [31:0]           stall_count
);

    logic [DATA_WIDTH-1:0] op1_s;
    logic [DATA_WIDTH-1:0] op2_s;
    logic                  haz1_s;
    logic                  haz2_s;
    logic                  stall_s;
    logic                  accept_s;

    assign rf_rd0 = in_rs1;
    assign rf_rd1 = in_rs2;

    operand_bypass #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_byp1 (
        .use_rs(in_use_rs1), .rs(in_rs1),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_data(rf_data0), .operand(op1_s), .hazard(haz1_s)
    );

    operand_bypass #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_byp2 (
        .use_rs(in_use_rs2), .rs(in_rs2),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_data(rf_data1), .operand(op2_s), .hazard(haz2_s)
    );

    assign stall_s  = in_valid && (haz1_s || haz2_s);
    assign in_ready = !rst && !flush && !stall_s && (!out_valid || out_ready);
    assign accept_s = in_valid && in_ready;

    // ID/EX register: flush beats accept, accept beats drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op1   <= {DATA_WIDTH{1'b0}};
            out_op2   <= {DATA_WIDTH{1'b0}};
            out_rd    <= {AW{1'b0}};
            out_ctrl  <= {CTRL_WIDTH{1'b0}};
            out_pc    <= 32'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_op1   <= op1_s;
            out_op2   <= op2_s;
            out_rd    <= in_rd;
            out_ctrl  <= in_ctrl;
            out_pc    <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 32'd0;
        end else if (stall_s && (stall_count != {32{1'b1}})) begin
            stall_count <= stall_count + 32'd1;
        end else begin
            stall_count <= stall_count;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs1, in_use_rs2;
    logic [15:0] in_ctrl;
    logic [31:0] in_pc;
    logic [4:0]  rf_rd0, rf_rd1;
    logic [31:0] rf_data0, rf_data1;
    logic        ex_wr_en, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        mem_wr_en;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_wr_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic [15:0] out_ctrl;
    logic [31:0] out_pc;
    logic [31:0] stall_count;

    logic [31:0] rf [32];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    assign rf_data0 = rf[rf_rd0];
    assign rf_data1 = rf[rf_rd1];

    operand_fetch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_ctrl(in_ctrl), .in_pc(in_pc),
        .rf_rd0(rf_rd0), .rf_rd1(rf_rd1), .rf_data0(rf_data0), .rf_data1(rf_data1),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_ctrl(out_ctrl),
        .out_pc(out_pc), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'h11;
        rf[3] = 32'h33;
        rf[5] = 32'h1234;
        rst = 1'b1; in_valid = 1'b1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
        in_use_rs1 = 1'b1; in_use_rs2 = 1'b1; in_ctrl = 16'h0; in_pc = 32'h0;
        ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_data = 32'h0;
        mem_wr_en = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
        wb_wr_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset held for two cycles with a valid instruction presented
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_in_ready2", {31'd0, in_ready}, 32'd0);

        // Plain register-file read
        rst = 1'b0; in_rs1 = 5'd5; in_rs2 = 5'd0; in_rd = 5'd9; in_ctrl = 16'h00AB; in_pc = 32'h100;
        #1;
        chk("rf_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rf_out_valid", {31'd0, out_valid}, 32'd1);
        chk("rf_op1", out_op1, 32'h1234);
        chk("rf_op2", out_op2, 32'h0);
        chk("rf_rd", {27'd0, out_rd}, 32'd9);
        chk("rf_ctrl", {16'd0, out_ctrl}, 32'h00AB);
        chk("rf_pc", out_pc, 32'h100);

        // Bypass priority EX > MEM > WB
        in_rs1 = 5'd7; in_pc = 32'h104;
        ex_wr_en = 1'b1; ex_rd = 5'd7; ex_data = 32'hA;
        mem_wr_en = 1'b1; mem_rd = 5'd7; mem_data = 32'hB;
        wb_wr_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hC;
        tick();
        chk("byp_ex", out_op1, 32'hA);
        ex_wr_en = 1'b0; in_pc = 32'h108;
        tick();
        chk("byp_mem", out_op1, 32'hB);
        mem_wr_en = 1'b0; in_pc = 32'h10C;
        tick();
        chk("byp_wb", out_op1, 32'hC);
        chk("byp_wb_pc", out_pc, 32'h10C);

        // x0 is never forwarded
        wb_wr_en = 1'b0; in_rs1 = 5'd1; in_rs2 = 5'd0;
        ex_wr_en = 1'b1; ex_rd = 5'd0; ex_data = 32'hFFFF; in_pc = 32'h110;
        tick();
        chk("x0_op2", out_op2, 32'h0);
        chk("x0_op1", out_op1, 32'h11);

        // Load-use stall on rs2, resolved through MEM next cycle
        in_rs1 = 5'd0; in_rs2 = 5'd3; in_rd = 5'd4; in_pc = 32'h200;
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
        #1;
        chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("lu_stall_count", stall_count, 32'd1);
        chk("lu_drain", {31'd0, out_valid}, 32'd0);
        ex_wr_en = 1'b0; ex_is_load = 1'b0;
        mem_wr_en = 1'b1; mem_rd = 5'd3; mem_data = 32'h55;
        #1;
        chk("lu_ready_after", {31'd0, in_ready}, 32'd1);
        tick();
        chk("lu_op2", out_op2, 32'h55);
        chk("lu_pc", out_pc, 32'h200);
        chk("lu_count_hold", stall_count, 32'd1);

        // Unused rs2 never stalls
        mem_wr_en = 1'b0; in_use_rs2 = 1'b0; in_pc = 32'h280;
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
        #1;
        chk("nouse_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("nouse_valid", {31'd0, out_valid}, 32'd1);
        chk("nouse_count", stall_count, 32'd1);

        // Backpressure for three cycles
        ex_wr_en = 1'b0; ex_is_load = 1'b0; in_use_rs2 = 1'b1;
        out_ready = 1'b0; in_rs1 = 5'd5; in_rs2 = 5'd0; in_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_pc", out_pc, 32'h280);
        end

        // Flush while stuck: squashes the held instruction, accepts nothing
        flush = 1'b1;
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_pc_not_loaded", out_pc, 32'h280);
        flush = 1'b0;
        tick();
        chk("post_fl_valid", {31'd0, out_valid}, 32'd1);
        chk("post_fl_pc", out_pc, 32'h300);
        chk("post_fl_op1", out_op1, 32'h1234);

        // Reset mid-operation clears everything
        rst = 1'b1;
        tick();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_pc", out_pc, 32'd0);
        chk("midrst_count", stall_count, 32'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
